// File: rtl/mul_pkg.sv
// Shared definitions for the sequential shift-add multiplier: widths,
// FSM state encodings and a small operand-gating helper.
package mul_pkg;

    localparam int MUL_W = 64;
    localparam int CNT_W = 6;

    typedef logic [1:0] mul_state_t;

    localparam mul_state_t ST_IDLE = 2'b00;
    localparam mul_state_t ST_EXEC = 2'b01;
    localparam mul_state_t ST_DONE = 2'b10;

    // Counter value at which the final shift-add step is taken.
    localparam logic [CNT_W-1:0] CNT_LAST = 6'd63;

    // Select the multiplicand as addend when the current multiplier bit is set.
    function automatic logic [MUL_W-1:0] gate_addend(
        input logic [MUL_W-1:0] mcand,
        input logic             sel
    );
        logic [MUL_W-1:0] res;
        if (sel) begin
            res = mcand;
        end else begin
            res = {MUL_W{1'b0}};
        end
        return res;
    endfunction

endpackage

// File: rtl/cla64.sv
// 64-bit carry-lookahead adder: 4-bit lookahead groups whose group
// carries ripple from group to group, including across the 32-bit halves.
module cla64
    import mul_pkg::*;
(
    input  logic [MUL_W-1:0] a,
    input  logic [MUL_W-1:0] b,
    input  logic             ci,
    output logic [MUL_W-1:0] sum,
    output logic             co
);

    logic [MUL_W-1:0] g_s;
    logic [MUL_W-1:0] p_s;
    logic [MUL_W-1:0] sum_s;
    logic             co_s;

    assign g_s = a & b;
    assign p_s = a ^ b;

    // Per-group lookahead carries, group carry chained into the next group.
    always_comb begin : carry_chain
        logic [3:0] gv;
        logic [3:0] pv;
        logic [3:0] cv;
        logic       grp_g;
        logic       grp_p;
        logic       cg_v;
        gv    = 4'b0000;
        pv    = 4'b0000;
        cv    = 4'b0000;
        grp_g = 1'b0;
        grp_p = 1'b0;
        cg_v  = ci;
        sum_s = {MUL_W{1'b0}};
        for (int k = 0; k < MUL_W / 4; k++) begin
            gv    = g_s[4*k +: 4];
            pv    = p_s[4*k +: 4];
            cv[0] = cg_v;
            cv[1] = gv[0] | (pv[0] & cg_v);
            cv[2] = gv[1] | (pv[1] & gv[0]) | (pv[1] & pv[0] & cg_v);
            cv[3] = gv[2] | (pv[2] & gv[1]) | (pv[2] & pv[1] & gv[0])
                  | (pv[2] & pv[1] & pv[0] & cg_v);
            grp_g = gv[3] | (pv[3] & gv[2]) | (pv[3] & pv[2] & gv[1])
                  | (pv[3] & pv[2] & pv[1] & gv[0]);
            grp_p = &pv;
            sum_s[4*k +: 4] = pv ^ cv;
            cg_v  = grp_g | (grp_p & cg_v);
        end
        co_s = cg_v;
    end

    assign sum = sum_s;
    assign co  = co_s;

endmodule

// File: rtl/multiplier_seq.sv
// Sequential 64x64->128 unsigned shift-add multiplier. One conditional add
// and one right shift per clock through the shared cla64 adder; fixed
// latency of 64 steps followed by a one-cycle DONE state.
module multiplier_seq
    import mul_pkg::*;
#(
    parameter int WIDTH = MUL_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               op_start,
    input  logic               op_clear,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic [2*WIDTH-1:0] result,
    output logic               op_done,
    output logic               busy
);

    mul_state_t         state_r;
    mul_state_t         state_nxt_s;
    logic [WIDTH-1:0]   mcand_r;
    logic [WIDTH-1:0]   acc_hi_r;
    logic [WIDTH-1:0]   acc_lo_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [2*WIDTH-1:0] result_r;
    logic               op_done_r;
    logic               busy_r;

    logic [WIDTH-1:0]   addend_s;
    logic [WIDTH-1:0]   sum_s;
    logic               co_s;
    logic [2*WIDTH-1:0] step_s;
    logic               last_step_s;

    // The adder carry-out is kept as the new top bit, so no overflow is possible.
    cla64 u_cla64 (
        .a   (acc_hi_r),
        .b   (addend_s),
        .ci  (1'b0),
        .sum (sum_s),
        .co  (co_s)
    );

    // Addend selection and the shifted running value for this step.
    always_comb begin
        addend_s    = gate_addend(mcand_r, acc_lo_r[0]);
        step_s      = {co_s, sum_s, acc_lo_r[WIDTH-1:1]};
        last_step_s = (cnt_r == CNT_LAST);
    end

    // Next-state decode; clear dominates and start is only honoured in IDLE.
    always_comb begin
        state_nxt_s = state_r;
        if (op_clear) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (op_start) begin
                        state_nxt_s = ST_EXEC;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_EXEC: begin
                    if (last_step_s) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_EXEC;
                    end
                end
                ST_DONE: state_nxt_s = ST_IDLE;
                default: state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // Control registers: state, registered status flags and the product.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            busy_r    <= 1'b0;
            op_done_r <= 1'b0;
            result_r  <= {(2*WIDTH){1'b0}};
        end else begin
            state_r   <= state_nxt_s;
            busy_r    <= (state_nxt_s != ST_IDLE);
            op_done_r <= (state_nxt_s == ST_DONE);
            if (op_clear) begin
                result_r <= {(2*WIDTH){1'b0}};
            end else if ((state_r == ST_EXEC) && last_step_s) begin
                result_r <= step_s;
            end
        end
    end

    // Operand, accumulator and step counter; frozen while a clear is asserted.
    always_ff @(posedge clk) begin
        if (reset) begin
            mcand_r  <= {WIDTH{1'b0}};
            acc_hi_r <= {WIDTH{1'b0}};
            acc_lo_r <= {WIDTH{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
        end else if (!op_clear) begin
            case (state_r)
                ST_IDLE: begin
                    if (op_start) begin
                        mcand_r  <= multiplicand;
                        acc_hi_r <= {WIDTH{1'b0}};
                        acc_lo_r <= multiplier;
                        cnt_r    <= {CNT_W{1'b0}};
                    end
                end
                ST_EXEC: begin
                    acc_hi_r <= step_s[2*WIDTH-1:WIDTH];
                    acc_lo_r <= step_s[WIDTH-1:0];
                    cnt_r    <= cnt_r + 6'd1;
                end
                default: begin
                end
            endcase
        end
    end

    assign result  = result_r;
    assign op_done = op_done_r;
    assign busy    = busy_r;

endmodule

// File: tb/tb_multiplier_seq.sv
// Self-checking bench for multiplier_seq: directed scenarios plus randomized
// operands, compared against a plain 128-bit arithmetic product.
module tb_multiplier_seq;

    logic         clk;
    logic         reset;
    logic         op_start;
    logic         op_clear;
    logic [63:0]  multiplicand;
    logic [63:0]  multiplier;
    logic [127:0] result;
    logic         op_done;
    logic         busy;

    int n_vec;
    int n_miss;

    multiplier_seq dut (
        .clk          (clk),
        .reset        (reset),
        .op_start     (op_start),
        .op_clear     (op_clear),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .result       (result),
        .op_done      (op_done),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against the expected one.
    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One multiply. abort_cyc (0 = none) asserts clear or reset during that
    // cycle; poke_a/poke_b (0 = none) pulse a spurious start with 99*99.
    task automatic do_op(input logic [63:0] a, input logic [63:0] b,
                         input int abort_cyc, input bit use_reset,
                         input int poke_a, input int poke_b);
        logic [127:0] prod;
        bit aborted;
        prod = {64'd0, a} * {64'd0, b};
        aborted = 1'b0;
        multiplicand = a;
        multiplier   = b;
        op_start     = 1'b1;
        tick();
        op_start     = 1'b0;
        multiplicand = {$urandom, $urandom};
        multiplier   = {$urandom, $urandom};
        for (int c = 1; c <= 66; c++) begin
            if (aborted) begin
                check_eq("abort_busy", 128'(busy), 128'd0);
                check_eq("abort_done", 128'(op_done), 128'd0);
                check_eq("abort_result", result, 128'd0);
                break;
            end else begin
                check_eq("busy", 128'(busy), (c <= 65) ? 128'd1 : 128'd0);
                check_eq("op_done", 128'(op_done), (c == 65) ? 128'd1 : 128'd0);
                if (c >= 65) begin
                    check_eq("result", result, prod);
                end
            end
            if (c == poke_a || c == poke_b) begin
                op_start     = 1'b1;
                multiplicand = 64'd99;
                multiplier   = 64'd99;
            end
            if (c == abort_cyc) begin
                if (use_reset) reset = 1'b1;
                else op_clear = 1'b1;
                aborted = 1'b1;
            end
            tick();
            op_start = 1'b0;
            op_clear = 1'b0;
            reset    = 1'b0;
        end
    endtask

    // Watchdog so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] ra;
        logic [63:0] rb;
        int sel;
        n_vec        = 0;
        n_miss       = 0;
        reset        = 1'b1;
        op_start     = 1'b0;
        op_clear     = 1'b0;
        multiplicand = 64'd0;
        multiplier   = 64'd0;
        tick();
        tick();
        check_eq("rst_result", result, 128'd0);
        check_eq("rst_done", 128'(op_done), 128'd0);
        check_eq("rst_busy", 128'(busy), 128'd0);
        reset = 1'b0;
        tick();

        do_op(64'd3, 64'd5, 0, 1'b0, 0, 0);
        do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1'b0, 0, 0);
        do_op(64'h1234, 64'd0, 0, 1'b0, 0, 0);
        do_op(64'd0, 64'd7, 0, 1'b0, 0, 0);
        do_op(64'd10, 64'd20, 0, 1'b0, 10, 65);
        check_eq("idle_after_poke", 128'(busy), 128'd0);
        do_op(64'hDEAD_BEEF, 64'hCAFE, 30, 1'b0, 0, 0);
        do_op(64'd7, 64'd6, 0, 1'b0, 0, 0);
        do_op(64'hABCD_EF01_2345_6789, 64'h1111, 64, 1'b1, 0, 0);
        do_op(64'h1_0000_0000, 64'h1_0000_0000, 0, 1'b0, 0, 0);

        // Clear beats a simultaneous start in IDLE.
        op_start     = 1'b1;
        op_clear     = 1'b1;
        multiplicand = 64'd5;
        multiplier   = 64'd5;
        tick();
        op_start = 1'b0;
        op_clear = 1'b0;
        check_eq("clr_vs_start_busy", 128'(busy), 128'd0);
        check_eq("clr_vs_start_result", result, 128'd0);
        tick();
        check_eq("clr_vs_start_idle", 128'(busy), 128'd0);

        for (int i = 0; i < 16; i++) begin
            sel = int'($urandom_range(0, 5));
            ra  = {$urandom, $urandom};
            rb  = {$urandom, $urandom};
            if (sel == 0) ra = 64'hFFFF_FFFF_FFFF_FFFF;
            if (sel == 1) rb = 64'd1;
            if (sel == 2) ra = {32'd0, ra[31:0]};
            if ($urandom_range(0, 3) == 0) begin
                do_op(ra, rb, int'($urandom_range(1, 65)), 1'($urandom_range(0, 1)), 0, 0);
            end else begin
                do_op(ra, rb, 0, 1'b0, int'($urandom_range(0, 65)), 0);
            end
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                tick();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
